// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmitter FSM state codes and the clocks-per-bit helper.
package uart_tx_fifo_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Rounded clocks per bit.
  function automatic int unsigned uart_div(input int unsigned freq, input int unsigned rate);
    return (freq + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy count; push is ignored when full, pop when empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; frames are sent back-to-back while the FIFO holds data.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned FREQ       = 1_000_000,
  parameter int unsigned RATE       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_vld,
  output logic       o_rdy,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned DIV = uart_div(FREQ, RATE);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [2:0]                  state_q, state_d;
  logic [BW-1:0]               baud_q, baud_d;
  logic [2:0]                  bit_q, bit_d;
  logic [7:0]                  shift_q, shift_d;
  logic                        tx_q, tx_d;
  logic                        fifo_pop, fifo_full, fifo_empty, load;
  logic [7:0]                  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        baud_end;
`ifdef UART_TX_PARITY_EN
  logic                        par_q, par_d;
`endif

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (i_vld),
    .wdata (i_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_rdy    = !fifo_full;
  assign o_tx     = tx_q;
  assign o_busy   = (state_q != IDLE) || (fifo_count != '0);
  assign baud_end = (baud_q == BW'(DIV - 1));
  assign fifo_pop = load;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        load   = !fifo_empty;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          load    = !fifo_empty;
          state_d = IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Zero-gap start: head byte is popped straight into the shifter.
    if (load) begin
      shift_d = fifo_rdata;
      tx_d    = 1'b0;
      baud_d  = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a serial decoder pops and checks.
module tb_uart_tx_fifo;

  localparam int FREQ = 1_000_000;
  localparam int RATE = 115_200;
  localparam int DIV  = (FREQ + RATE / 2) / RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk, rst_n, i_vld, o_rdy, o_tx, o_busy;
  logic [7:0] i_data;

  uart_tx_fifo #(
    .FREQ       (FREQ),
    .RATE       (RATE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (i_data),
    .i_vld  (i_vld),
    .o_rdy  (o_rdy),
    .o_tx   (o_tx),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  int          start_q [$];
  bit          saw_stall;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Serial decoder: samples each bit at its centre, relative to the falling start edge.
  bit         mon_act = 0;
  int         mon_t, mon_k;
  logic [7:0] mon_byte, mon_exp;
  logic       mon_par;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (o_tx == 1'b0) begin
        mon_act  = 1;
        mon_t    = 0;
        mon_byte = '0;
        mon_par  = 1'b0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_t++;
      if (mon_t % DIV == DIV / 2) begin
        mon_k = mon_t / DIV;
        if (mon_k == 0) begin
          check("start_bit", int'(o_tx), 0);
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = o_tx;
        end else if (mon_k < NB - 1) begin
          mon_par = o_tx;
        end else begin
          check("stop_bit", int'(o_tx), 1);
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", int'(mon_byte), -1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rx_data", int'(mon_byte), int'(mon_exp));
`ifdef UART_TX_PARITY_EN
            check("rx_parity", int'(mon_par), int'(^mon_exp));
`endif
          end
          mon_act = 0;
        end
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input bit keep);
    int guard = 0;
    bit hs;
    i_data = b;
    i_vld  = 1'b1;
    do begin
      hs = o_rdy;
      if (!hs) saw_stall = 1;
      @(posedge clk);
      guard++;
    end while (!hs && guard < 2000);
    if (hs) exp_q.push_back(b);
    else check("push_timeout", 0, 1);
    #1;
    if (!keep) i_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || o_busy || mon_act) && g < 5000) begin
      @(posedge clk);
      g++;
    end
    check(name, int'(g < 5000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_gaps(input string name, input int n);
    check({name, "_frames"}, start_q.size(), n);
    for (int i = 1; i < start_q.size(); i++)
      check({name, "_gap"}, start_q[i] - start_q[i-1], NB * DIV);
  endtask

  initial begin
    int bad;
    rst_n  = 1'b0;
    i_vld  = 1'b0;
    i_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", int'(o_tx), 1);
    check("reset_rdy", int'(o_rdy), 1);
    check("reset_busy", int'(o_busy), 0);
    rst_n = 1'b1;

    // Idle line with no input.
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("idle_violations", bad, 0);
    @(posedge clk);
    #1;

    // Single byte: first-transaction latency.
    push_byte(8'h6A, 0);
    check("latency_tx_before", int'(o_tx), 1);
    check("latency_busy", int'(o_busy), 1);
    @(posedge clk);
    #1;
    check("latency_tx_low", int'(o_tx), 0);
    wait_drain("drain_6a");
    push_byte(8'h07, 0);
    wait_drain("drain_07");

    // Burst of four: head is popped while the rest arrive, so ready never drops.
    start_q.delete();
    for (int i = 1; i <= 4; i++) push_byte(8'(i), i < 4);
    check("burst_rdy", int'(o_rdy), 1);
    wait_drain("drain_burst");
    check_gaps("burst", 4);

    // Six bytes with valid held high: ready must stall, nothing lost.
    saw_stall = 0;
    start_q.delete();
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)), i < 5);
    check("six_stall_seen", int'(saw_stall), 1);
    wait_drain("drain_six");
    check_gaps("six", 6);

    // Random bytes with random gaps.
    for (int i = 0; i < 24; i++) begin
      push_byte(8'($urandom_range(0, 255)), 0);
      repeat ($urandom_range(0, 25)) @(posedge clk);
      #1;
    end
    wait_drain("drain_random");

    // Reset in the middle of the data bits of 0x55 (bit1 = 0 is on the line).
    push_byte(8'h55, 0);
    repeat (1 + 2 * DIV + 4) @(posedge clk);
    #1;
    check("mid_frame_tx_low", int'(o_tx), 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_tx", int'(o_tx), 1);
    check("abort_busy", int'(o_busy), 0);
    check("abort_rdy", int'(o_rdy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("post_abort_quiet", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
